// File: rtl/fir_par.sv
// fir_par: time-multiplexed FIR filter with one shared multiplier.
// A sample is accepted in IDLE and shifted into the delay line. MAC then
// spends TAPS cycles accumulating x[k]*h[k] at full precision. The final
// sum is rounded half up, shifted right by FRAC, saturated to DATA_W bits,
// and held in OUT until the consumer takes it.
//
// Ports:
//   clk                  rising-edge clock
//   rst                  synchronous active-low reset
//   in_valid/in_ready    input sample handshake (ready only in IDLE)
//   in_data              signed input sample, DATA_W bits
//   out_valid/out_ready  output handshake
//   out_data             signed filtered sample, DATA_W bits
//   coef_we              coefficient write strobe (honoured only in IDLE)
//   coef_addr            tap index
//   coef_data            signed coefficient, COEF_W bits with FRAC fraction bits
//   busy                 high while a sample is being processed or held
module fir_par #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 8,
    parameter int FRAC   = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [COEF_W-1:0]       coef_data,
    output logic                    busy
);

    localparam int AW    = $clog2(TAPS);
    localparam int PW    = DATA_W + COEF_W;
    localparam int ACC_W = PW + AW;
    localparam logic [ACC_W-1:0] RND = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC - 1);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                    state_q, state_d;
    logic [AW-1:0]             k_q, k_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [DATA_W-1:0]  x_q [TAPS];
    logic signed [DATA_W-1:0]  x_d [TAPS];
    logic signed [COEF_W-1:0]  h_q [TAPS];
    logic signed [COEF_W-1:0]  h_d [TAPS];
    logic                      out_valid_q, out_valid_d;
    logic [DATA_W-1:0]         out_data_q, out_data_d;

    logic                      accept;
    logic signed [PW-1:0]      prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   sum;
    logic signed [ACC_W-1:0]   rounded;
    logic signed [ACC_W-1:0]   shifted;
    logic [ACC_W-DATA_W:0]     top_bits;
    logic [DATA_W-1:0]         sat;

    // Gated with rst so nothing is offered while reset is held.
    assign in_ready  = rst && (state_q == IDLE);
    assign busy      = rst && (state_q != IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Shared multiplier and output datapath.
    always_comb begin
        prod     = x_q[k_q] * h_q[k_q];
        prod_ext = prod;
        sum      = acc_q + prod_ext;
        rounded  = sum + $signed(RND);
        shifted  = rounded >>> FRAC;
        // Value fits when every bit above the result sign matches it.
        top_bits = shifted[ACC_W-1:DATA_W-1];
        if (top_bits == '0 || top_bits == '1) begin
            sat = shifted[DATA_W-1:0];
        end else if (shifted[ACC_W-1]) begin
            sat = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            sat = {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        acc_d       = acc_q;
        x_d         = x_q;
        h_d         = h_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    for (int unsigned i = TAPS - 1; i > 0; i--) begin
                        x_d[i] = x_q[i-1];
                    end
                    x_d[0]  = in_data;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = MAC;
                end else if (coef_we && (int'(coef_addr) < TAPS)) begin
                    h_d[coef_addr] = coef_data;
                end
            end
            MAC: begin
                acc_d = sum;
                if (k_q == AW'(TAPS - 1)) begin
                    out_data_d  = sat;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end else begin
                    k_d = k_q + AW'(1);
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int unsigned i = 0; i < TAPS; i++) begin
                x_q[i] <= '0;
                h_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            for (int unsigned i = 0; i < TAPS; i++) begin
                x_q[i] <= x_d[i];
                h_q[i] <= h_d[i];
            end
        end
    end

endmodule
